// File: rtl/encoder_16_to_4_seq.sv
// Sequential 16-to-4 encoder: accepts a multi-hot vector and emits the index of
// every set bit, one per handshaked beat, flagging the final beat with o_last.
module encoder_16_to_4_seq #(
  parameter bit ORDER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_e,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_d,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [3:0]  o_a,
  output logic        o_last,
  output logic        o_zero
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      r_state, w_state_n;
  logic [15:0] r_pend, w_pend_n;
  logic        r_zflag, w_zflag_n;

  logic [3:0]  w_idx;
  logic        w_onehot, w_last, w_scan, w_fire, w_acc;

  // Later matches win, so the loop direction selects lowest vs highest set bit.
  always_comb begin
    w_idx = '0;
    if (ORDER == 1'b0) begin
      for (int i = 15; i >= 0; i--) if (r_pend[i]) w_idx = 4'(i);
    end else begin
      for (int i = 0; i < 16; i++) if (r_pend[i]) w_idx = 4'(i);
    end
  end

  assign w_onehot = (r_pend != '0) && ((r_pend & (r_pend - 16'd1)) == '0);
  assign w_scan   = i_rst_n && (r_state == SCAN);
  assign w_last   = w_onehot || r_zflag;

  assign o_out_valid = w_scan && i_e;
  assign o_a         = w_scan ? w_idx : '0;
  assign o_last      = w_scan && w_last;
  assign o_zero      = w_scan && r_zflag;

  assign w_fire     = o_out_valid && i_out_ready;
  // out_ready feeds in_ready directly so a new vector can land on the final beat.
  assign o_in_ready = i_e && i_rst_n && ((r_state == IDLE) || (w_fire && w_last));
  assign w_acc      = i_in_valid && o_in_ready;

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_zflag_n = r_zflag;
    if (w_fire) begin
      w_pend_n = r_pend & ~(16'd1 << w_idx);
      if (w_last) w_state_n = IDLE;
    end
    if (w_acc) begin
      w_pend_n  = i_d;
      w_zflag_n = (i_d == '0);
      w_state_n = SCAN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_zflag <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_zflag <= w_zflag_n;
    end
  end

endmodule

// File: tb/tb_encoder_16_to_4_seq.sv
// Bench for encoder_16_to_4_seq: both scan orders side by side, directed cases
// then randomized vectors checked against a bit-list model.
module tb_encoder_16_to_4_seq;

  logic        clk = 1'b0;
  logic        rst_n, e, in_valid, out_ready;
  logic [15:0] d;
  logic        in_ready0, out_valid0, last0, zero0;
  logic        in_ready1, out_valid1, last1, zero1;
  logic [3:0]  a0, a1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_16_to_4_seq #(.ORDER(1'b0)) u_asc (
    .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_in_valid(in_valid), .o_in_ready(in_ready0),
    .i_d(d), .o_out_valid(out_valid0), .i_out_ready(out_ready), .o_a(a0),
    .o_last(last0), .o_zero(zero0));

  encoder_16_to_4_seq #(.ORDER(1'b1)) u_dsc (
    .i_clk(clk), .i_rst_n(rst_n), .i_e(e), .i_in_valid(in_valid), .o_in_ready(in_ready1),
    .i_d(d), .o_out_valid(out_valid1), .i_out_ready(out_ready), .o_a(a1),
    .o_last(last1), .o_zero(zero1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out_valid0"}, 16'(out_valid0), 16'd0);
    chk({tag, " out_valid1"}, 16'(out_valid1), 16'd0);
  endtask

  // Accept vector v, then consume all its beats; the first `first_stalls` cycles
  // hold out_ready low, afterwards out_ready is random (rnd) or always high.
  task automatic run_vec(input logic [15:0] v, input int first_stalls, input bit rnd);
    int asc[$];
    int dsc[$];
    int k, n, cyc, stalls;
    for (int i = 0; i < 16; i++) if (v[i]) asc.push_back(i);
    if (asc.size() == 0) asc.push_back(0);
    for (int i = asc.size() - 1; i >= 0; i--) dsc.push_back(asc[i]);
    n = asc.size();
    in_valid = 1'b1; d = v; out_ready = 1'b0;
    #1;
    chk("accept in_ready0", 16'(in_ready0), 16'd1);
    chk("accept in_ready1", 16'(in_ready1), 16'd1);
    tick();
    in_valid = 1'b0; d = 16'($urandom);
    k = 0; cyc = 0; stalls = 0;
    while (k < n && cyc < 200) begin
      if (cyc < first_stalls) out_ready = 1'b0;
      else if (rnd && stalls < 4) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      stalls = out_ready ? 0 : stalls + 1;
      #1;
      chk("beat valid0", 16'(out_valid0), 16'd1);
      chk("beat valid1", 16'(out_valid1), 16'd1);
      chk("beat a0", 16'(a0), 16'(asc[k]));
      chk("beat a1", 16'(a1), 16'(dsc[k]));
      chk("beat last0", 16'(last0), 16'(k == n - 1));
      chk("beat last1", 16'(last1), 16'(k == n - 1));
      chk("beat zero0", 16'(zero0), 16'(v == 16'd0));
      chk("beat zero1", 16'(zero1), 16'(v == 16'd0));
      if (out_ready) k++;
      cyc++;
      tick();
    end
    chk("beat budget", 16'(k), 16'(n));
    out_ready = 1'b0;
    #1;
    chk_idle("post vector");
    chk("post in_ready0", 16'(in_ready0), 16'd1);
  endtask

  initial begin
    logic [15:0] v;
    e = 1'b1; out_ready = 1'b1;

    // Reset held with a full vector offered: nothing may be accepted.
    rst_n = 1'b0; in_valid = 1'b1; d = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst in_ready0", 16'(in_ready0), 16'd0);
      chk("rst in_ready1", 16'(in_ready1), 16'd0);
      chk_idle("rst");
      chk("rst a0", 16'(a0), 16'd0);
      chk("rst a1", 16'(a1), 16'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("after rst");
    end

    run_vec(16'h8421, 0, 1'b0);
    run_vec(16'h0000, 0, 1'b0);
    run_vec(16'h0003, 3, 1'b0);
    run_vec(16'hFFFF, 0, 1'b0);

    // Back-to-back: second vector accepted on the final beat of the first.
    in_valid = 1'b1; d = 16'h0100; out_ready = 1'b1;
    tick();
    d = 16'h0010;
    #1;
    chk("b2b a0", 16'(a0), 16'd8);
    chk("b2b last0", 16'(last0), 16'd1);
    chk("b2b in_ready0", 16'(in_ready0), 16'd1);
    chk("b2b in_ready1", 16'(in_ready1), 16'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b2 valid0", 16'(out_valid0), 16'd1);
    chk("b2b2 a0", 16'(a0), 16'd4);
    chk("b2b2 a1", 16'(a1), 16'd4);
    chk("b2b2 last0", 16'(last0), 16'd1);
    tick();
    chk_idle("b2b end");

    // Enable freeze after the first beat of 16'h00F0.
    in_valid = 1'b1; d = 16'h00F0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("en a0 first", 16'(a0), 16'd4);
    chk("en a1 first", 16'(a1), 16'd7);
    tick();
    e = 1'b0; in_valid = 1'b1; d = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_idle("en off");
      chk("en off in_ready0", 16'(in_ready0), 16'd0);
      tick();
    end
    e = 1'b1; in_valid = 1'b0;
    #1;
    chk("en resume valid0", 16'(out_valid0), 16'd1);
    chk("en resume a0", 16'(a0), 16'd5);
    chk("en resume a1", 16'(a1), 16'd6);
    tick();
    // Mid-scan reset discards the remaining bits.
    rst_n = 1'b0;
    #1;
    chk_idle("mid rst comb");
    chk("mid rst a0", 16'(a0), 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_idle("mid rst after");
      chk("mid rst in_ready0", 16'(in_ready0), 16'd1);
      tick();
    end

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1: v = 16'd1 << $urandom_range(0, 15);
        2: v = (t % 8 == 0) ? 16'd0 : 16'($urandom);
        default: v = 16'($urandom);
      endcase
      run_vec(v, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_16_to_4_seq.md
# encoder_16_to_4_seq

Sequential 16-to-4 encoder: the return path for our 4-to-16 decoders. It accepts a 16-bit multi-hot vector through a valid/ready handshake and emits the 4-bit index of every set bit, one index per output beat, with a last flag on the final beat. It sits wherever a set of one-hot or multi-hot select or request lines must be turned back into binary addresses, e.g. for serialising interrupt or request vectors onto a 4-bit bus.

## Interface
- ORDER, default 0: scan order. 0 emits ascending indices (bit 0 first); 1 emits descending indices (bit 15 first).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low.
- E  in  1  enable. When 0, the block freezes: in_ready=0, out_valid=0, and no state changes.
- in_valid  in  1  D is valid.
- in_ready  out  1  the block can accept D this cycle.
- D  in  16  input vector (multi-hot allowed).
- out_valid  out  1  A, last and zero are valid.
- out_ready  in  1  the consumer accepts the current beat.
- A  out  4  encoded bit index.
- last  out  1  final beat of the current vector.
- zero  out  1  the accepted vector was all-zero.

## Operation
- State machine: IDLE and SCAN. Registers:
  - pend[15:0]: bits of the vector not yet emitted.
  - zflag: set when the accepted vector was all-zero.
- Accept: an accept occurs when in_valid & in_ready at a clock edge. On accept:
  - pend <= D.
  - zflag <= (D == 0).
  - state <= SCAN.
- in_ready = E & rst_n & ((state == IDLE) | (out_valid & out_ready & last)).
  - The combinational path from out_ready to in_ready is intentional. It allows back-to-back vectors with no bubble.
- SCAN outputs:
  - out_valid = E.
  - A = index of the lowest set bit of pend when ORDER=0, or the highest set bit when ORDER=1.
  - last = 1 when pend has exactly one bit set, or when zflag=1.
  - zero = zflag.
- All-zero vector: produces exactly one beat with A=0, zero=1, last=1.
- Beat handshake: a beat completes on out_valid & out_ready at a clock edge. On completion:
  - The emitted bit is cleared in pend.
  - If last=1, state goes to IDLE, or straight back to SCAN with the new pend if an accept occurs in the same cycle. Otherwise state stays in SCAN.
- IDLE outputs: out_valid=0, A=0, last=0, zero=0.
- Stall (out_ready=0): A, last and zero are held stable. pend is unchanged.
- E=0: the state machine and pend are frozen. When E returns to 1, the same beat is re-presented.
- Reset (rst_n=0 at an edge):
  - state <= IDLE, pend <= 0, zflag <= 0.
  - While rst_n=0: in_ready=0, out_valid=0, A=0, last=0, zero=0.
  - Reset mid-scan discards all remaining bits; no further beats are emitted for that vector.
- Ignored inputs: D is ignored unless an accept occurs. in_valid in SCAN without the last-beat handshake is not accepted, and the producer must hold D.

## Timing
- Latency: accept at edge k, first beat valid in the cycle after edge k.
- Throughput:
  - A vector with N set bits takes max(N,1) beats, at one beat per cycle while out_ready=1.
  - The next vector can be accepted on the edge that completes the last beat.
- Outputs A, last, zero and out_valid are decoded from registered state plus the E gate. They have no combinational dependence on D.
- Reset takes effect at the first rising edge with rst_n=0. Outputs read as reset values from that edge until the first edge with rst_n=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, D=16'hFFFF -> in_ready=0, out_valid=0, A=0 throughout, and no beats after release until a new accept.
- Multi-hot, ORDER=0, out_ready=1: D=16'h8421 -> beats A=0,5,10,15 on 4 consecutive cycles, last=1 only with A=15, then IDLE. With ORDER=1 -> A=15,10,5,0.
- Zero vector: D=16'h0000 -> a single beat with A=0, zero=1, last=1, then in_ready=1 the next cycle.
- Backpressure: D=16'h0003, out_ready=0 for 3 cycles, then 1 -> A=0 and last=0 held stable for 3 cycles, then beats A=0 then A=1 (last=1).
- Back-to-back: D=16'h0100 accepted, then in_valid=1 with D=16'h0010 during its last beat (out_ready=1) -> in_ready=1 in that cycle, and the next cycle shows A=4, last=1 with no idle bubble.
- E and mid-scan reset:
  - D=16'h00F0; drop E=0 for 2 cycles after the A=4 beat -> out_valid=0 and in_ready=0; on E=1, A=5 resumes.
  - Repeat with rst_n=0 pulsed after the A=5 beat -> no A=6 or A=7 beats; the block returns to IDLE.
